noc_inject_port: RTL and testbench

//  Endpoint-to-router injection stage. Accepts a valid/ready flit stream (data, dest, last) from a

---
 rtl/noc_inject_port.sv | 221 ++++++++++++++++++++++
 tb/tb_noc_inject_port.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_inject_port.sv
// noc_inject_port
//   Endpoint-to-router injection stage. Client flits (data, dest, last) are
//   buffered in a small FIFO. Each one is issued to the router as a single-cycle
//   send pulse, and only while the credit counter shows free slots in the
//   router's input buffer. A framing FSM holds the head flit's dest across the
//   body flits. It also cuts packets that reach MAX_PKT_FLITS by forcing a tail.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   s_data/s_dest/s_last      client flit; s_dest is used on head flits only
//   s_valid/s_ready           client handshake; s_ready = FIFO not full
//   data_out/dest_out         registered flit to the router
//   is_tail_out/send_out      tail marker and one-cycle send strobe
//   credit_in                 one pulse per slot freed in the router
//   credit_err                sticky: credit returned while counter full
//   len_err                   sticky: a packet was truncated
//   flit_count/pkt_count      only when NOC_INJECT_STATS_EN is defined
//
// Configuration macro: NOC_INJECT_STATS_EN (adds flit/packet counters).
module noc_inject_port #(
  parameter int FLIT_WIDTH    = 256,
  parameter int DEST_WIDTH    = 3,
  parameter int CREDIT_DEPTH  = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_PKT_FLITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] s_data,
  input  logic [DEST_WIDTH-1:0] s_dest,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic                  credit_err,
`ifdef NOC_INJECT_STATS_EN
  output logic [31:0]           flit_count,
  output logic [31:0]           pkt_count,
`endif
  output logic                  len_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CREDIT_DEPTH) + 1;
  localparam int FW = $clog2(MAX_PKT_FLITS + 1);

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  last;
  } ent_t;

  typedef enum logic {S_HEAD, S_BODY} state_t;

  ent_t [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic [DEST_WIDTH-1:0] cur_dest_q, cur_dest_d;
  state_t                state_q, state_d;
  logic                  en_q;
  logic [FLIT_WIDTH-1:0] data_q, data_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic                  tail_q, tail_d;
  logic                  send_q;
  logic                  credit_err_q, credit_err_d;
  logic                  len_err_q, len_err_d;
  logic                  full, empty, acc, pop;
  ent_t                  rd_ent;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  // en_q keeps s_ready low while rst is held and for no longer.
  assign s_ready = en_q & ~full;
  assign acc    = s_valid & s_ready;
  assign pop    = ~empty & (cnt_q != '0);
  assign rd_ent = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (acc) begin
      mem_d[wr_ptr_q[PW-1:0]] = '{data: s_data, dest: s_dest, last: s_last};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Credit counter: a simultaneous return and pop cancel out. A return with
  // the counter already full is dropped and flagged.
  always_comb begin
    cnt_d        = cnt_q;
    credit_err_d = credit_err_q;
    if (credit_in && !pop) begin
      if (cnt_q == CW'(CREDIT_DEPTH)) credit_err_d = 1'b1;
      else                            cnt_d = cnt_q + 1'b1;
    end else if (!credit_in && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Framing FSM and output register; all of it moves only on pop.
  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    cur_dest_d = cur_dest_q;
    data_d     = data_q;
    dest_d     = dest_q;
    tail_d     = tail_q;
    len_err_d  = len_err_q;
    if (pop) begin
      data_d = rd_ent.data;
      case (state_q)
        S_HEAD: begin
          dest_d     = rd_ent.dest;
          cur_dest_d = rd_ent.dest;
          fcnt_d     = FW'(1);
          if (rd_ent.last || MAX_PKT_FLITS == 1) begin
            tail_d  = 1'b1;
            state_d = S_HEAD;
            // A one-flit limit truncates any non-tail head.
            if (!rd_ent.last) len_err_d = 1'b1;
          end else begin
            tail_d  = 1'b0;
            state_d = S_BODY;
          end
        end
        default: begin
          dest_d = cur_dest_q;
          fcnt_d = fcnt_q + 1'b1;
          if (rd_ent.last) begin
            tail_d  = 1'b1;
            state_d = S_HEAD;
          end else if (fcnt_q + FW'(1) == FW'(MAX_PKT_FLITS)) begin
            // Limit reached: force a tail. The client's remaining flits
            // then start a fresh packet.
            tail_d    = 1'b1;
            len_err_d = 1'b1;
            state_d   = S_HEAD;
          end else begin
            tail_d = 1'b0;
          end
        end
      endcase
    end
  end

  // Payload storage has no reset; emptiness is tracked by the pointers.
  always_ff @(posedge clk) mem_q <= mem_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= CW'(CREDIT_DEPTH);
      fcnt_q       <= '0;
      cur_dest_q   <= '0;
      state_q      <= S_HEAD;
      en_q         <= 1'b0;
      data_q       <= '0;
      dest_q       <= '0;
      tail_q       <= 1'b0;
      send_q       <= 1'b0;
      credit_err_q <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      fcnt_q       <= fcnt_d;
      cur_dest_q   <= cur_dest_d;
      state_q      <= state_d;
      en_q         <= 1'b1;
      data_q       <= data_d;
      dest_q       <= dest_d;
      tail_q       <= tail_d;
      send_q       <= pop;
      credit_err_q <= credit_err_d;
      len_err_q    <= len_err_d;
    end
  end

  assign data_out    = data_q;
  assign dest_out    = dest_q;
  assign is_tail_out = tail_q;
  assign send_out    = send_q;
  assign credit_err  = credit_err_q;
  assign len_err     = len_err_q;

`ifdef NOC_INJECT_STATS_EN
  logic [31:0] flit_count_q, flit_count_d, pkt_count_q, pkt_count_d;

  always_comb begin
    flit_count_d = flit_count_q;
    pkt_count_d  = pkt_count_q;
    if (pop) begin
      flit_count_d = flit_count_q + 32'd1;
      if (tail_d) pkt_count_d = pkt_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_count_q <= '0;
      pkt_count_q  <= '0;
    end else begin
      flit_count_q <= flit_count_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign flit_count = flit_count_q;
  assign pkt_count  = pkt_count_q;
`endif

endmodule

// File: tb/tb_noc_inject_port.sv
// Testbench for noc_inject_port. A packet-level reference model predicts each
// flit's framing when the flit is accepted and queues the prediction. A
// negedge monitor pops the queue on every send pulse and also acts as the
// router, returning credits and tracking buffer occupancy.
module tb_noc_inject_port;
  localparam int FLW = 64;
  localparam int DW  = 3;
  localparam int CD  = 2;
  localparam int FD  = 4;
  localparam int MPF = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [FLW-1:0] s_data = '0;
  logic [DW-1:0]  s_dest = '0;
  logic           s_last = 1'b0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [FLW-1:0] data_out;
  logic [DW-1:0]  dest_out;
  logic           is_tail_out, send_out, credit_err, len_err;
  logic           credit_in = 1'b0;
`ifdef NOC_INJECT_STATS_EN
  logic [31:0]    flit_count, pkt_count;
`endif

  noc_inject_port #(.FLIT_WIDTH(FLW), .DEST_WIDTH(DW), .CREDIT_DEPTH(CD),
                    .FIFO_DEPTH(FD), .MAX_PKT_FLITS(MPF)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_dest(s_dest), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready), .data_out(data_out), .dest_out(dest_out),
    .is_tail_out(is_tail_out), .send_out(send_out), .credit_in(credit_in),
    .credit_err(credit_err),
`ifdef NOC_INJECT_STATS_EN
    .flit_count(flit_count), .pkt_count(pkt_count),
`endif
    .len_err(len_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [FLW-1:0] d;
    logic [DW-1:0]  dest;
    logic           tail;
    logic           len;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   sends = 0, tails = 0, outstanding = 0;
  bit   auto_cr = 1'b0, man_cr = 1'b0;

  // Reference model state: packet position and the sticky truncation flag.
  bit          m_in_body = 1'b0;
  bit          m_len = 1'b0;
  int          m_cnt = 0;
  logic [DW-1:0] m_dest = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic model_push(input logic [FLW-1:0] d, input logic [DW-1:0] dst, input logic lst);
    exp_t e;
    if (!m_in_body) begin m_dest = dst; m_cnt = 1; end
    else m_cnt++;
    e.tail = lst || (m_cnt == MPF);
    if (e.tail && !lst) m_len = 1'b1;
    m_in_body = !e.tail;
    e.d = d; e.dest = m_dest; e.len = m_len;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [FLW-1:0] d, input logic [DW-1:0] dst, input logic lst);
    int n = 0;
    s_data = d; s_dest = dst; s_last = lst; s_valid = 1'b1;
    while (!s_ready && n < 300) begin @(negedge clk); n++; end
    if (!s_ready) begin
      checks++; failures++;
      $display("FAIL push_timeout got=s_ready_low exp=s_ready_high");
      s_valid = 1'b0;
      return;
    end
    model_push(d, dst, lst);
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic pkt(input int len, input logic [DW-1:0] hd, input logic [DW-1:0] bd, input bit gaps);
    for (int i = 0; i < len; i++) begin
      push({$urandom, $urandom}, (i == 0) ? hd : bd, i == len - 1);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || outstanding != 0) && n < 1000) begin @(posedge clk); n++; end
    chk("drain_pending", 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic set_mode(input bit a);
    @(posedge clk); auto_cr = a;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    sb.delete(); m_in_body = 0; m_len = 0; m_cnt = 0;
    outstanding = 0; sends = 0; tails = 0;
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_send", 64'(send_out), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_dest_tail", {dest_out, is_tail_out}, 64'd0);
    chk("rst_errs", {credit_err, len_err}, 64'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post_rst_s_ready", 64'(s_ready), 64'd1);
  endtask

  // Monitor and router model.
  always @(negedge clk) begin
    exp_t e;
    if (rst) credit_in = 1'b0;
    else begin
      if (send_out) begin
        sends++; outstanding++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_send got=dest%0h_tail%0h exp=no_send", dest_out, is_tail_out);
        end else begin
          e = sb.pop_front();
          if (e.tail) tails++;
          if (data_out !== e.d || dest_out !== e.dest || is_tail_out !== e.tail || len_err !== e.len) begin
            failures++;
            $display("FAIL flit got=%h/%0h/%0b/%0b exp=%h/%0h/%0b/%0b",
                     data_out, dest_out, is_tail_out, len_err, e.d, e.dest, e.tail, e.len);
          end
        end
        checks++;
        if (outstanding > CD) begin
          failures++;
          $display("FAIL router_overflow got=%0d exp<=%0d", outstanding, CD);
        end
      end
      if (man_cr) begin
        credit_in = 1'b1;
        if (outstanding > 0) outstanding--;
      end else if (auto_cr && outstanding > 0 && $urandom_range(0, 2) != 0) begin
        credit_in = 1'b1;
        outstanding--;
      end else credit_in = 1'b0;
    end
  end

  int s0;
  initial begin
    do_reset();

    // Mid-packet reset: no credits, 5 body flits -> 2 sent, 3 left buffered.
    pkt(5, 3'd1, 3'd1, 1'b0);
    s_last = 1'b0;
    repeat (10) @(negedge clk);
    chk("t1_stalled_sends", 64'(sends), 64'd2);
    do_reset();
    // The head after reset must carry its own dest; credits are back at 2.
    push(64'h1111, 3'd6, 1'b1);
    for (int i = 0; i < 3; i++) push({$urandom, $urandom}, 3'($urandom), 1'b1);
    repeat (10) @(negedge clk);
    chk("t1_cnt_after_rst", 64'(sends), 64'd2);
    set_mode(1'b1);
    drain();

    // Single-flit packet with its latency.
    @(negedge clk);
    push(64'hABCD, 3'd5, 1'b1);
    chk("t2_send_early", 64'(send_out), 64'd0);
    @(negedge clk);
    chk("t2_send_pulse", 64'(send_out), 64'd1);
    @(negedge clk);
    chk("t2_pulse_width", 64'(send_out), 64'd0);
    drain();

    // Body dest hold.
    @(negedge clk);
    pkt(4, 3'd3, 3'd7, 1'b0);
    drain();
    chk("t4_len_err_clear", 64'(len_err), 64'd0);

    // Length limit: 6 flits with a limit of 4.
    @(negedge clk);
    pkt(6, 3'd2, 3'd4, 1'b0);
    drain();
    chk("t5_len_err", 64'(len_err), 64'd1);

    // Credit stall, then one credit per cycle.
    set_mode(1'b0);
    s0 = sends;
    @(negedge clk);
    fork
      pkt(6, 3'd4, 3'd0, 1'b0);
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t3_stall_sends", 64'(sends - s0), 64'd2);
        chk("t3_fifo_full", 64'(s_ready), 64'd0);
        @(posedge clk); man_cr = 1'b1;
        repeat (4) @(posedge clk); man_cr = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        chk("t3_resume_sends", 64'(sends - s0), 64'd6);
      end
    join
    set_mode(1'b1);
    drain();
    chk("t3_credit_err_clear", 64'(credit_err), 64'd0);

    // Credit overflow while full and idle; the counter must stay at 2.
    set_mode(1'b0);
    @(posedge clk); man_cr = 1'b1;
    @(posedge clk); man_cr = 1'b0;
    @(negedge clk);
    chk("t6_credit_err", 64'(credit_err), 64'd1);
    s0 = sends;
    for (int i = 0; i < 3; i++) push({$urandom, $urandom}, 3'($urandom), 1'b1);
    repeat (15) @(negedge clk);
    chk("t6_cnt_saturated", 64'(sends - s0), 64'd2);
    set_mode(1'b1);
    drain();

`ifdef NOC_INJECT_STATS_EN
    chk("stats_flits_run", 64'(flit_count), 64'(sends));
    chk("stats_pkts_run", 64'(pkt_count), 64'(tails));
    do_reset();
    set_mode(1'b1);
    @(negedge clk);
    pkt(3, 3'd1, 3'd1, 1'b0);
    pkt(3, 3'd2, 3'd2, 1'b0);
    drain();
    chk("stats_flit_count", 64'(flit_count), 64'd6);
    chk("stats_pkt_count", 64'(pkt_count), 64'd2);
`endif

    // Randomised traffic: mixed lengths (some over the limit), gaps, credits.
    do_reset();
    set_mode(1'b1);
    @(negedge clk);
    for (int p = 0; p < 40; p++)
      pkt($urandom_range(1, 6), 3'($urandom), 3'($urandom), 1'b1);
    drain();
    chk("rand_credit_err", 64'(credit_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
